// File: rtl/multi_timer.sv
// multi_timer: memory-mapped multi-channel timer with a free-running cycle counter.
// Each channel has a prescaler, an up-counter, a compare register, a periodic or
// one-shot mode and a maskable level interrupt. The bus reads data_out one cycle
// after ren.

// Per-channel timer: prescaler, counter, compare, control bits and pending flag.
module multi_timer_chan #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_pre,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        clr,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    input  logic [1:0]  rd_off,
    output logic [31:0] rdata,
    output logic        pending,
    output logic        irq
);

    logic             en;
    logic             oneshot;
    logic             irq_en;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pcnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] compare;

    logic             tick;
    logic             match;
    logic             restart;
    logic [2:0]       ctrl_new;
    logic [PRE_W-1:0] pre_new;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W-1:0] cmp_new;

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

    // Next values for each register if written, plus tick/match qualification.
    always_comb begin
        ctrl_new = 3'(merge(32'({irq_en, oneshot, en}), wdata, wmask));
        pre_new  = PRE_W'(merge(32'(prescale), wdata, wmask));
        cnt_new  = CNT_W'(merge(32'(count), wdata, wmask));
        cmp_new  = CNT_W'(merge(32'(compare), wdata, wmask));
        tick     = en && (pcnt == prescale);
        // A software COUNT write in the same cycle suppresses match evaluation.
        match    = tick && (count == compare) && !wr_cnt;
        restart  = (wr_ctrl && ctrl_new[0]) || wr_pre || wr_cnt;
    end

    // Channel state update; software writes take priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            oneshot  <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= '0;
            compare  <= '0;
            pending  <= 1'b0;
        end else begin
            if (restart || tick)
                pcnt <= '0;
            else if (en)
                pcnt <= pcnt + 1'b1;

            if (wr_cnt)
                count <= cnt_new;
            else if (match)
                count <= '0;
            else if (tick)
                count <= count + 1'b1;

            if (wr_ctrl)
                {irq_en, oneshot, en} <= ctrl_new;
            else if (match && oneshot)
                en <= 1'b0;

            if (wr_pre)
                prescale <= pre_new;
            if (wr_cmp)
                compare <= cmp_new;

            // A new match beats a simultaneous W1C.
            if (match)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

    // Register readback for the selected offset.
    always_comb begin
        case (rd_off)
            2'd0:    rdata = {29'd0, irq_en, oneshot, en};
            2'd1:    rdata = 32'(prescale);
            2'd2:    rdata = 32'(count);
            default: rdata = 32'(compare);
        endcase
    end

    assign irq = pending & irq_en;

endmodule

// Top level: address decode, channel array, STATUS/CYCLES and registered read port.
module multi_timer #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int PRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ren,
    input  logic                wen,
    input  logic [7:0]          address,
    input  logic [31:0]         data_in,
    input  logic [3:0]          byte_select,
    output logic [31:0]         data_out,
    output logic [CHANNELS-1:0] irq
);

    logic [2:0]                 sel_ch;
    logic [1:0]                 sel_off;
    logic                       ch_hit;
    logic                       glb_hit;
    logic [31:0]                wmask;
    logic [31:0]                rdata;
    logic [31:0]                cycles;
    logic [CHANNELS-1:0][31:0]  rd_ch;
    logic [CHANNELS-1:0]        pending;
    logic                       unused_addr;

    // Channels live at c*0x10 below 0x80; globals sit in the 0x70 slot.
    assign sel_ch      = address[6:4];
    assign sel_off     = address[3:2];
    assign ch_hit      = !address[7] && (int'(sel_ch) < CHANNELS);
    assign glb_hit     = (address[7:4] == 4'h7);
    assign wmask       = {{8{byte_select[3]}}, {8{byte_select[2]}},
                          {8{byte_select[1]}}, {8{byte_select[0]}}};
    assign unused_addr = ^address[1:0];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic hit;
        logic clr;
        assign hit = wen && ch_hit && (sel_ch == 3'(c));
        // STATUS bits live in byte lane 0.
        assign clr = wen && glb_hit && (sel_off == 2'd0) && byte_select[0] && data_in[c];

        multi_timer_chan #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_ctrl (hit && (sel_off == 2'd0)),
            .wr_pre  (hit && (sel_off == 2'd1)),
            .wr_cnt  (hit && (sel_off == 2'd2)),
            .wr_cmp  (hit && (sel_off == 2'd3)),
            .clr     (clr),
            .wdata   (data_in),
            .wmask   (wmask),
            .rd_off  (sel_off),
            .rdata   (rd_ch[c]),
            .pending (pending[c]),
            .irq     (irq[c])
        );
    end

    // Read mux; unmapped addresses return 0.
    always_comb begin
        rdata = '0;
        if (glb_hit) begin
            case (sel_off)
                2'd0:    rdata = 32'(pending);
                2'd1:    rdata = cycles;
                default: rdata = '0;
            endcase
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (ch_hit && (sel_ch == 3'(c)))
                    rdata = rd_ch[c];
        end
    end

    // Free-running cycle counter and registered read data (held between reads).
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles   <= '0;
            data_out <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (ren)
                data_out <= rdata;
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: three instances (CNT_W 32/16/8) share one bus.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ren;
    logic        wen;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [3:0]  byte_select;
    logic [31:0] rd0, rd16, rd8;
    logic [3:0]  irq0, irq16, irq8;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int n;
    int t1, t2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_timer dut0 (
        .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
        .data_in(data_in), .byte_select(byte_select), .data_out(rd0), .irq(irq0));

    multi_timer #(.CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
        .data_in(data_in), .byte_select(byte_select), .data_out(rd16), .irq(irq16));

    multi_timer #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
        .data_in(data_in), .byte_select(byte_select), .data_out(rd8), .irq(irq8));

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] bs);
        @(negedge clk);
        address = a; data_in = d; byte_select = bs; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        @(negedge clk);
        address = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ren = 1'b0; wen = 1'b0; address = 8'h00; data_in = '0; byte_select = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL reset_dout: got %h want 0", rd0); end
        cmp_cnt++; if ({irq0, irq16, irq8} !== 12'h0) begin err_cnt++; $display("FAIL reset_irq: got %h want 0", {irq0, irq16, irq8}); end
        bus_read(8'h74);
        cmp_cnt++; if (rd0 !== 32'h1) begin err_cnt++; $display("FAIL reset_cycles: got %h want 1", rd0); end
        bus_read(8'h0C);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL reset_compare: got %h want 0", rd0); end
    endtask

    task automatic test_periodic;
        bus_write(8'h04, 32'd2, 4'hF);
        bus_write(8'h0C, 32'd3, 4'hF);
        bus_write(8'h00, 32'h5, 4'hF);
        n = 0;
        while (!irq0[0] && n < 100) begin @(posedge clk); #1; n++; end
        cmp_cnt++; if (n !== 12) begin err_cnt++; $display("FAIL periodic_first: got %0d clks want 12", n); end
        t1 = cyc;
        bus_read(8'h08);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL periodic_count0: got %h want 0", rd0); end
        bus_write(8'h70, 32'h1, 4'hF);
        cmp_cnt++; if (irq0[0] !== 1'b0) begin err_cnt++; $display("FAIL periodic_w1c: got %b want 0", irq0[0]); end
        n = 0;
        while (!irq0[0] && n < 100) begin @(posedge clk); #1; n++; end
        t2 = cyc;
        cmp_cnt++; if (t2 - t1 !== 12) begin err_cnt++; $display("FAIL periodic_second: got %0d clks want 12", t2 - t1); end
    endtask

    task automatic test_w1c_vs_match;
        // pending[0] is still set from the previous match; next match is 12 clks after t2.
        while (cyc != t2 + 11) @(negedge clk);
        address = 8'h70; data_in = 32'h1; byte_select = 4'hF; wen = 1'b1;
        @(posedge clk); #1;
        cmp_cnt++; if (irq0[0] !== 1'b1) begin err_cnt++; $display("FAIL w1c_vs_match_irq: got %b want 1", irq0[0]); end
        @(negedge clk);
        wen = 1'b0;
        bus_read(8'h70);
        cmp_cnt++; if (rd0 !== 32'h1) begin err_cnt++; $display("FAIL w1c_vs_match_status: got %h want 1", rd0); end
        bus_write(8'h70, 32'h1, 4'hF);
        cmp_cnt++; if (irq0[0] !== 1'b0) begin err_cnt++; $display("FAIL w1c_after: got %b want 0", irq0[0]); end
        bus_write(8'h00, 32'h0, 4'hF);
        bus_read(8'h70);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL w1c_status_clear: got %h want 0", rd0); end
    endtask

    task automatic test_oneshot;
        bus_write(8'h14, 32'd0, 4'hF);
        bus_write(8'h1C, 32'd5, 4'hF);
        bus_write(8'h10, 32'h7, 4'hF);
        n = 0;
        while (!irq0[1] && n < 100) begin @(posedge clk); #1; n++; end
        cmp_cnt++; if (n !== 6) begin err_cnt++; $display("FAIL oneshot_ticks: got %0d want 6", n); end
        bus_read(8'h10);
        cmp_cnt++; if (rd0 !== 32'h6) begin err_cnt++; $display("FAIL oneshot_ctrl: got %h want 6", rd0); end
        bus_read(8'h18);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL oneshot_count: got %h want 0", rd0); end
        repeat (20) @(negedge clk);
        bus_read(8'h18);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL oneshot_hold: got %h want 0", rd0); end
        cmp_cnt++; if (irq0[1] !== 1'b1) begin err_cnt++; $display("FAIL oneshot_irq_level: got %b want 1", irq0[1]); end
        bus_write(8'h70, 32'h2, 4'hF);
        cmp_cnt++; if (irq0 !== 4'h0) begin err_cnt++; $display("FAIL oneshot_clear: got %h want 0", irq0); end
    endtask

    task automatic test_byte_lanes;
        bus_write(8'h2C, 32'hAABBCCDD, 4'b0011);
        bus_read(8'h2C);
        cmp_cnt++; if (rd0 !== 32'h0000CCDD) begin err_cnt++; $display("FAIL lanes_low: got %h want 0000ccdd", rd0); end
        bus_write(8'h2C, 32'hAABBCCDD, 4'hF);
        bus_read(8'h2C);
        cmp_cnt++; if (rd0 !== 32'hAABBCCDD) begin err_cnt++; $display("FAIL lanes_full32: got %h want aabbccdd", rd0); end
        cmp_cnt++; if (rd16 !== 32'h0000CCDD) begin err_cnt++; $display("FAIL lanes_full16: got %h want 0000ccdd", rd16); end
        cmp_cnt++; if (rd8 !== 32'h000000DD) begin err_cnt++; $display("FAIL lanes_full8: got %h want 000000dd", rd8); end
        bus_write(8'h2C, 32'h11223344, 4'b0100);
        bus_read(8'h2C);
        cmp_cnt++; if (rd0 !== 32'hAA22CCDD) begin err_cnt++; $display("FAIL lanes_byte2: got %h want aa22ccdd", rd0); end
        bus_write(8'h24, 32'hFFFFFFFF, 4'hF);
        bus_read(8'h24);
        cmp_cnt++; if (rd0 !== 32'h0000FFFF) begin err_cnt++; $display("FAIL prescale_width: got %h want 0000ffff", rd0); end
    endtask

    task automatic test_unmapped;
        bus_write(8'h50, 32'h12345678, 4'hF);
        bus_read(8'h50);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL unmapped_ch5: got %h want 0", rd0); end
        bus_read(8'h78);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL unmapped_78: got %h want 0", rd0); end
        bus_write(8'h84, 32'hFF, 4'hF);
        bus_read(8'h04);
        cmp_cnt++; if (rd0 !== 32'h2) begin err_cnt++; $display("FAIL no_alias_84: got %h want 2", rd0); end
    endtask

    task automatic test_rw_same;
        @(negedge clk);
        address = 8'h2C; data_in = 32'h12345678; byte_select = 4'hF; wen = 1'b1; ren = 1'b1;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        cmp_cnt++; if (rd0 !== 32'hAA22CCDD) begin err_cnt++; $display("FAIL rw_same_old: got %h want aa22ccdd", rd0); end
        bus_read(8'h2C);
        cmp_cnt++; if (rd0 !== 32'h12345678) begin err_cnt++; $display("FAIL rw_same_new: got %h want 12345678", rd0); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_seq [5];
        exp_seq = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'h00};
        bus_write(8'h34, 32'h0, 4'hF);
        bus_write(8'h3C, 32'h1, 4'hF);
        bus_write(8'h38, 32'hFE, 4'hF);
        bus_write(8'h30, 32'h1, 4'hF);
        address = 8'h38; ren = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (rd8 !== exp_seq[i]) begin err_cnt++; $display("FAIL wrap_seq%0d: got %h want %h", i, rd8, exp_seq[i]); end
        end
        ren = 1'b0;
        bus_read(8'h70);
        cmp_cnt++; if ((rd8 & 32'h8) !== 32'h8) begin err_cnt++; $display("FAIL wrap_pending: got %h want bit3 set", rd8); end
        bus_write(8'h30, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] addrs [11];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h2C, 8'h38, 8'h70};
        bus_write(8'h00, 32'h5, 4'hF);
        bus_write(8'h10, 32'h5, 4'hF);
        repeat (10) @(negedge clk);
        cmp_cnt++; if (irq0[1] !== 1'b1) begin err_cnt++; $display("FAIL midrun_running: got %b want 1", irq0[1]); end
        reset = 1'b1; address = 8'h74; ren = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL midrun_ren_in_reset: got %h want 0", rd0); end
        cmp_cnt++; if (irq0 !== 4'h0) begin err_cnt++; $display("FAIL midrun_irq: got %h want 0", irq0); end
        @(negedge clk);
        cmp_cnt++; if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL midrun_cycles0: got %h want 0", rd0); end
        @(negedge clk);
        ren = 1'b0;
        cmp_cnt++; if (rd0 !== 32'h1) begin err_cnt++; $display("FAIL midrun_cycles1: got %h want 1", rd0); end
        for (int i = 0; i < 11; i++) begin
            bus_read(addrs[i]);
            cmp_cnt++;
            if (rd0 !== 32'h0) begin err_cnt++; $display("FAIL midrun_reg_%h: got %h want 0", addrs[i], rd0); end
        end
        cmp_cnt++; if (irq0 !== 4'h0) begin err_cnt++; $display("FAIL midrun_irq_after: got %h want 0", irq0); end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_w1c_vs_match;
        test_oneshot;
        test_byte_lanes;
        test_unmapped;
        test_rw_same;
        test_wrap;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised, memory-mapped multi-channel timer that replaces the two fixed `cpuTimer` instances (1 MHz and 27 MHz free-running counters) in the SoC. It provides `CHANNELS` independent channels, each with a programmable prescaler, an up-counter, a compare register, periodic or one-shot mode and a maskable interrupt. It also provides one free-running cycle counter. The block sits on the SoC bus as a slave: the bus decodes its region and drives `ren`/`wen`, and the block returns `data_out` to the bus read mux.

## Interface
- `CHANNELS`, default 4: number of timer channels, 1..7.
- `CNT_W`, default 32: counter and compare width, 8..32.
- `PRE_W`, default 16: prescaler width, 1..32.
- `clk` input 1: system clock (`cpu_clk` domain).
- `reset` input 1: synchronous, active-high.
- `ren` input 1: read strobe, valid for one cycle.
- `wen` input 1: write strobe, valid for one cycle.
- `address` input 8: byte address within the block; bits [1:0] ignored.
- `data_in` input 32: write data.
- `byte_select` input 4: write byte-lane enables.
- `data_out` output 32: registered read data.
- `irq` output `CHANNELS`: per-channel level interrupt, equal to `pending & irq_en`.

## Operation
- Register map: channel c occupies base address c*0x10. Offsets within a channel:
  - 0x0 CTRL: bit0 `en`, bit1 `oneshot`, bit2 `irq_en`.
  - 0x4 PRESCALE (`PRE_W` bits).
  - 0x8 COUNT (`CNT_W` bits).
  - 0xC COMPARE (`CNT_W` bits).
- Global registers:
  - 0x70 STATUS: bit c = `pending[c]`; writing 1 clears the bit (W1C).
  - 0x74 CYCLES: free-running 32-bit counter; read-only; increments every clk, wraps 0xFFFFFFFF→0.
- Writes: applied per byte lane using `byte_select`. Bits beyond a register's width are ignored. Unmapped addresses ignore writes and read 0.
- Channel prescaler:
  - `pcnt` (`PRE_W` bits) increments each clk while `en`=1.
  - When `pcnt == PRESCALE`, `pcnt` goes to 0 and a tick occurs. PRESCALE=0 therefore ticks every clk; PRESCALE=N ticks every N+1 clks.
- Behaviour on a tick:
  - If COUNT == COMPARE: `pending` is set and COUNT goes to 0. If `oneshot`=1, `en` clears (CTRL bit0 reads 0 afterwards).
  - Otherwise COUNT increments by 1 and wraps at 2^`CNT_W`.
- Disabled channel: `pcnt` and COUNT hold; `pending` is not set.
- Writing CTRL with `en`=1, or any write to COUNT or PRESCALE, clears `pcnt` to 0.
- Per-channel state: IDLE (`en`=0) → RUN (write `en`=1) → IDLE (write `en`=0, or one-shot match).

## Timing
- Reset values: all registers 0, `pcnt`=0, `pending`=0, CYCLES=0, `data_out`=0, `irq`=0.
- Read latency: 1 cycle. `data_out` is sampled from the registers on the `ren` edge and is valid the following cycle. It holds until the next `ren`.
- Write effect: a register write is visible on the next clk. A read issued the cycle after a write returns the new value.
- Counting latency: a tick is evaluated on the clk edge where `pcnt == PRESCALE`. `pending`, and therefore `irq`, rise on that same edge.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
  - STATUS W1C in the same cycle as a new match on that channel: the set wins, and `pending` stays 1.
  - CTRL write in the same cycle as a one-shot match: the CTRL write wins.
- COMPARE written below the current COUNT: the channel counts up through wrap to COMPARE. No special handling.
- `reset` asserted mid-count: all state returns to reset values on the next edge. Any `ren` in that cycle returns 0.
- `ren` and `wen` together to the same address: the write applies, and the read returns the pre-write value.
- `irq` is combinational from `pending` and `irq_en`, with no extra register stage.

## Test plan
- Periodic: ch0 PRESCALE=2, COMPARE=3, CTRL=0x5. Required: `irq[0]` first rises 12 clks after the CTRL write takes effect; COUNT reads 0 immediately after; after W1C, `irq[0]` rises again 12 clks later.
- One-shot: ch1 PRESCALE=0, COMPARE=5, CTRL=0x7. Required: `pending[1]` sets after 6 ticks; CTRL then reads 0x6; COUNT stays 0 for at least 20 further clks.
- Byte lanes and widths: write 0xAABBCCDD to ch2 COMPARE with `byte_select`=0b0011. Required: reads back 0x0000CCDD. With `CNT_W`=16, a full-word write reads back 0x0000CCDD.
- Simultaneous W1C and match: time the STATUS write of 0x1 to the same clk as the ch0 match. Required: `pending[0]` stays 1; a subsequent W1C clears it.
- Reset mid-run: two channels enabled and counting, assert `reset` for 1 clk. Required: all readbacks are 0, `irq`=0, and CYCLES restarts from 0 (reads 1 on the first cycle read after deassert + read latency).
- Wrap: `CNT_W`=8, COUNT=0xFE, COMPARE=0x01, PRESCALE=0. Required: COUNT sequence 0xFF, 0x00, 0x01, then match sets `pending`.
